// File: rtl/jtopl_wrarb.sv
// jtopl_wrarb: arbitrates register-write requests from two requesters and
// turns each accepted request into an address write followed by a data
// write on the jtopl_mmr port, with cen-paced wait states after each write.
module jtopl_wrarb #(
  parameter int ADDR_WAIT = 1,
  parameter int DATA_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req0,
  input  logic [7:0] reg0,
  input  logic [7:0] val0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] reg1,
  input  logic [7:0] val1,
  output logic       ack1,
  output logic [7:0] din,
  output logic       write,
  output logic       addr,
  output logic       busy,
  output logic       gnt
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    AWAIT,
    DATA,
    DWAIT
  } state_t;

  localparam logic [7:0] AWAIT_LAST = 8'(ADDR_WAIT);
  localparam logic [7:0] DWAIT_LAST = 8'(DATA_WAIT);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] lat_val, lat_val_nx;
  logic [7:0] din_nx;
  logic       write_nx, addr_nx, ack0_nx, ack1_nx, busy_nx, gnt_nx;
  logic       pick;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    lat_val_nx = lat_val;
    din_nx     = din;
    addr_nx    = addr;
    gnt_nx     = gnt;
    write_nx   = 1'b0;
    ack0_nx    = 1'b0;
    ack1_nx    = 1'b0;
    pick       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not granted last time wins
          pick       = (req0 && req1) ? ~gnt : req1;
          gnt_nx     = pick;
          lat_val_nx = pick ? val1 : val0;
          din_nx     = pick ? reg1 : reg0;
          addr_nx    = 1'b0;
          write_nx   = 1'b1;
          ack0_nx    = ~pick;
          ack1_nx    = pick;
          state_nx   = ADDR;
        end
      end
      ADDR: begin
        cnt_nx   = 8'd0;
        state_nx = AWAIT;
      end
      AWAIT: begin
        if (cnt == AWAIT_LAST) begin
          din_nx   = lat_val;
          addr_nx  = 1'b1;
          write_nx = 1'b1;
          state_nx = DATA;
        end else if (cen) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DATA: begin
        cnt_nx   = 8'd0;
        state_nx = DWAIT;
      end
      DWAIT: begin
        if (cnt == DWAIT_LAST) begin
          state_nx = IDLE;
        end else if (cen) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State, counter, latched value and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      lat_val <= 8'd0;
      din     <= 8'd0;
      write   <= 1'b0;
      addr    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
      gnt     <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lat_val <= lat_val_nx;
      din     <= din_nx;
      write   <= write_nx;
      addr    <= addr_nx;
      ack0    <= ack0_nx;
      ack1    <= ack1_nx;
      busy    <= busy_nx;
      gnt     <= gnt_nx;
    end
  end

endmodule

// File: tb/tb_jtopl_wrarb.sv
// tb_jtopl_wrarb: drives three differently parameterised arbiters with the
// same requests and compares every output against a transaction-level model,
// plus fixed vector tables and directed corner-case sequences.
module tb_jtopl_wrarb;

  localparam int NDUT = 3;
  localparam int PH_IDLE = 0;
  localparam int PH_ADDR = 1;
  localparam int PH_AGAP = 2;
  localparam int PH_DATA = 3;
  localparam int PH_DGAP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       req0, req1;
  logic [7:0] reg0, val0, reg1, val1;

  logic       o_ack0  [NDUT];
  logic       o_ack1  [NDUT];
  logic       o_write [NDUT];
  logic       o_addr  [NDUT];
  logic       o_busy  [NDUT];
  logic       o_gnt   [NDUT];
  logic [7:0] o_din   [NDUT];

  int checks = 0;
  int failures = 0;

  // model state: which step of the transaction, cen pulses still to wait
  int         m_phase [NDUT];
  int         m_left  [NDUT];
  logic [7:0] m_val   [NDUT];
  logic       e_write [NDUT];
  logic       e_addr  [NDUT];
  logic       e_ack0  [NDUT];
  logic       e_ack1  [NDUT];
  logic       e_busy  [NDUT];
  logic       e_gnt   [NDUT];
  logic [7:0] e_din   [NDUT];

  always #5 clk = ~clk;

  jtopl_wrarb #(.ADDR_WAIT(1), .DATA_WAIT(4)) dut0 (
    .clk(clk), .rst(rst), .cen(cen),
    .req0(req0), .reg0(reg0), .val0(val0), .ack0(o_ack0[0]),
    .req1(req1), .reg1(reg1), .val1(val1), .ack1(o_ack1[0]),
    .din(o_din[0]), .write(o_write[0]), .addr(o_addr[0]),
    .busy(o_busy[0]), .gnt(o_gnt[0])
  );

  jtopl_wrarb #(.ADDR_WAIT(2), .DATA_WAIT(3)) dut1 (
    .clk(clk), .rst(rst), .cen(cen),
    .req0(req0), .reg0(reg0), .val0(val0), .ack0(o_ack0[1]),
    .req1(req1), .reg1(reg1), .val1(val1), .ack1(o_ack1[1]),
    .din(o_din[1]), .write(o_write[1]), .addr(o_addr[1]),
    .busy(o_busy[1]), .gnt(o_gnt[1])
  );

  jtopl_wrarb #(.ADDR_WAIT(0), .DATA_WAIT(0)) dut2 (
    .clk(clk), .rst(rst), .cen(cen),
    .req0(req0), .reg0(reg0), .val0(val0), .ack0(o_ack0[2]),
    .req1(req1), .reg1(reg1), .val1(val1), .ack1(o_ack1[2]),
    .din(o_din[2]), .write(o_write[2]), .addr(o_addr[2]),
    .busy(o_busy[2]), .gnt(o_gnt[2])
  );

  function automatic int addrWait(input int i);
    case (i)
      0: return 1;
      1: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int dataWait(input int i);
    case (i)
      0: return 4;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  // One comparison: counts it and reports a mismatch
  task automatic compare(input string name, input int i, input logic [7:0] act,
                         input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d t=%0t actual=%0h required=%0h",
               name, i, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NDUT; i++) begin
      m_phase[i] = PH_IDLE;
      m_left[i]  = 0;
      m_val[i]   = 8'h00;
      e_write[i] = 1'b0;
      e_addr[i]  = 1'b0;
      e_ack0[i]  = 1'b0;
      e_ack1[i]  = 1'b0;
      e_busy[i]  = 1'b0;
      e_gnt[i]   = 1'b1;
      e_din[i]   = 8'h00;
    end
  endtask

  // Advances the model of one arbiter across the coming clock edge
  task automatic modelStep(input int i);
    logic who;
    e_write[i] = 1'b0;
    e_ack0[i]  = 1'b0;
    e_ack1[i]  = 1'b0;
    case (m_phase[i])
      PH_IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) who = !e_gnt[i];
          else who = req1;
          e_gnt[i]   = who;
          m_val[i]   = who ? val1 : val0;
          e_din[i]   = who ? reg1 : reg0;
          e_addr[i]  = 1'b0;
          e_write[i] = 1'b1;
          e_ack0[i]  = !who;
          e_ack1[i]  = who;
          m_phase[i] = PH_ADDR;
        end
      end
      PH_ADDR: begin
        m_phase[i] = PH_AGAP;
        m_left[i]  = addrWait(i);
      end
      PH_AGAP: begin
        if (m_left[i] == 0) begin
          m_phase[i] = PH_DATA;
          e_write[i] = 1'b1;
          e_addr[i]  = 1'b1;
          e_din[i]   = m_val[i];
        end else if (cen) begin
          m_left[i]--;
        end
      end
      PH_DATA: begin
        m_phase[i] = PH_DGAP;
        m_left[i]  = dataWait(i);
      end
      default: begin
        if (m_left[i] == 0) m_phase[i] = PH_IDLE;
        else if (cen) m_left[i]--;
      end
    endcase
    e_busy[i] = (m_phase[i] != PH_IDLE);
  endtask

  task automatic checkOutput(input int i);
    compare("write", i, 8'(o_write[i]), 8'(e_write[i]));
    compare("addr",  i, 8'(o_addr[i]),  8'(e_addr[i]));
    compare("din",   i, o_din[i],       e_din[i]);
    compare("ack0",  i, 8'(o_ack0[i]),  8'(e_ack0[i]));
    compare("ack1",  i, 8'(o_ack1[i]),  8'(e_ack1[i]));
    compare("busy",  i, 8'(o_busy[i]),  8'(e_busy[i]));
    compare("gnt",   i, 8'(o_gnt[i]),   8'(e_gnt[i]));
  endtask

  // Drives one cycle of inputs, steps the model and checks all arbiters
  task automatic applyStimulus(input logic r0, input logic [7:0] g0, input logic [7:0] v0,
                               input logic r1, input logic [7:0] g1, input logic [7:0] v1,
                               input logic c);
    @(negedge clk);
    req0 = r0; reg0 = g0; val0 = v0;
    req1 = r1; reg1 = g1; val1 = v1;
    cen  = c;
    for (int i = 0; i < NDUT; i++) modelStep(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) checkOutput(i);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; cen = 1'b1;
    reg0 = 8'h00; val0 = 8'h00; reg1 = 8'h00; val1 = 8'h00;
    #1;
    modelReset();
    for (int i = 0; i < NDUT; i++) checkOutput(i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       req0;
    logic [7:0] reg0;
    logic [7:0] val0;
    logic       cen;
    logic       write;
    logic       addr;
    logic [7:0] din;
    logic       ack0;
    logic       busy;
  } vec_t;

  vec_t vec [10];

  initial begin
    int q[$];
    int sum, extra, prev, n, bad, good;
    logic seen_addr, done, in_await, cn;
    logic rq0, rq1;
    logic [7:0] rg0, rv0, rg1, rv1;

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; cen = 1'b1;
    reg0 = 8'h00; val0 = 8'h00; reg1 = 8'h00; val1 = 8'h00;
    modelReset();

    // Single write at defaults on dut0, outputs one row per cycle from cycle 1
    vec[0] = '{1'b1, 8'hA0, 8'h55, 1'b1, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b1};
    vec[1] = '{1'b0, 8'hA0, 8'h55, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1};
    vec[2] = '{1'b0, 8'hA0, 8'h55, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1};
    vec[3] = '{1'b0, 8'hA0, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1};
    for (int k = 4; k < 9; k++)
      vec[k] = '{1'b0, 8'hA0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    vec[9] = '{1'b0, 8'hA0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};

    doReset();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(vec[k].req0, vec[k].reg0, vec[k].val0, 1'b0, 8'h00, 8'h00, vec[k].cen);
      compare("vec_write", k, 8'(o_write[0]), 8'(vec[k].write));
      compare("vec_addr",  k, 8'(o_addr[0]),  8'(vec[k].addr));
      compare("vec_din",   k, o_din[0],       vec[k].din);
      compare("vec_ack0",  k, 8'(o_ack0[0]),  8'(vec[k].ack0));
      compare("vec_busy",  k, 8'(o_busy[0]),  8'(vec[k].busy));
    end

    // Tie after reset: both requests held, grants alternate 0,1,0,1
    doReset();
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 8'h20, 8'h01, 1'b1, 8'h40, 8'h3F, 1'b1);
      if ((c + 1) % 10 == 1) begin
        compare("tie_ack0", c + 1, 8'(o_ack0[0]), 8'((((c + 1) / 10) % 2) == 0));
        compare("tie_ack1", c + 1, 8'(o_ack1[0]), 8'((((c + 1) / 10) % 2) == 1));
        compare("tie_din",  c + 1, o_din[0], ((((c + 1) / 10) % 2) == 1) ? 8'h40 : 8'h20);
      end
    end

    // Sparse cen on dut1 (ADDR_WAIT=2): record cen at each edge taken in AWAIT
    doReset();
    seen_addr = 1'b0; done = 1'b0; extra = 0;
    for (int c = 0; c < 60; c++) begin
      cn = ((c % 4) == 3);
      in_await = seen_addr && !done && !o_write[1];
      if (in_await) q.push_back(int'(cn));
      applyStimulus(c == 0, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, cn);
      if (!seen_addr && o_write[1] && !o_addr[1]) seen_addr = 1'b1;
      else if (seen_addr && !done && o_write[1]) begin
        if (o_addr[1]) done = 1'b1;
        else extra++;
      end
    end
    compare("sparse_data_seen", 1, 8'(done), 8'd1);
    compare("sparse_extra_write", 1, 8'(extra), 8'd0);
    if (q.size() >= 2) begin
      sum = 0;
      for (int k = 0; k < q.size() - 1; k++) sum += q[k];
      compare("sparse_cen_count", 1, 8'(sum), 8'd2);
      compare("sparse_last_cen", 1, 8'(q[q.size() - 2]), 8'd1);
    end else begin
      compare("sparse_await_len", 1, 8'(q.size()), 8'd2);
    end

    // Asynchronous reset while dut0 sits in AWAIT
    doReset();
    applyStimulus(1'b1, 8'hB0, 8'hC3, 1'b0, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'hB0, 8'hC3, 1'b0, 8'h00, 8'h00, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    for (int i = 0; i < NDUT; i++) checkOutput(i);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      if (o_write[0]) bad++;
    end
    compare("rst_no_write", 0, 8'(bad), 8'd0);

    // Withdrawn request: req1 pulses for one cycle while dut0 is busy
    doReset();
    bad = 0; good = 0;
    for (int c = 0; c < 25; c++) begin
      applyStimulus(c == 0, 8'h11, 8'h22, c == 2, 8'h99, 8'h77, 1'b1);
      if (o_ack1[0]) bad++;
      if (o_write[0] && (o_din[0] == 8'h99 || o_din[0] == 8'h77)) bad++;
      if (o_write[0] && o_addr[0] && o_din[0] == 8'h22) good++;
    end
    compare("withdraw_bad", 0, 8'(bad), 8'd0);
    compare("withdraw_data", 0, 8'(good), 8'd1);

    // Zero waits on dut2: back-to-back period of 5 cycles
    doReset();
    prev = -1; n = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b1, 8'h05, 8'h06, 1'b0, 8'h00, 8'h00, 1'b1);
      if (o_ack0[2]) begin
        if (prev >= 0) compare("zero_period", 2, 8'(c - prev), 8'd5);
        prev = c;
        n++;
      end
    end
    compare("zero_acks", 2, 8'(n), 8'd6);

    // Randomised requesters following dut0's acks, random cen
    doReset();
    rq0 = 1'b0; rq1 = 1'b0;
    rg0 = 8'h00; rv0 = 8'h00; rg1 = 8'h00; rv1 = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (rq0 && o_ack0[0]) rq0 = 1'b0;
      else if (rq0 && $urandom_range(0, 29) == 0) rq0 = 1'b0;
      else if (!rq0 && $urandom_range(0, 2) == 0) begin
        rq0 = 1'b1; rg0 = 8'($urandom); rv0 = 8'($urandom);
      end
      if (rq1 && o_ack1[0]) rq1 = 1'b0;
      else if (rq1 && $urandom_range(0, 29) == 0) rq1 = 1'b0;
      else if (!rq1 && $urandom_range(0, 2) == 0) begin
        rq1 = 1'b1; rg1 = 8'($urandom); rv1 = 8'($urandom);
      end
      cn = (c < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(rq0, rg0, rv0, rq1, rg1, rv1, cn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
